// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
// Turns a valid/ready stream of 32-bit instruction words into little-endian
// single-byte writes on the write port of a byte-wide instruction memory.
// A load is bounds-checked against MEM_BYTES before any byte is written.

module instruction_memory_loader #(
  parameter int MEM_BYTES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [63:0] i_base_addr,
  input  logic [15:0] i_num_words,
  input  logic        i_word_valid,
  input  logic [31:0] i_word_data,
  output logic        o_word_ready,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_WORD,
    WRITE,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [63:0] r_addr;
  logic [15:0] r_remaining;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic [63:0] r_last_addr;
  logic [7:0]  r_last_wdata;

  logic [81:0] w_end_addr;
  logic        w_bad_request;
  logic [7:0]  w_cur_byte;

  // The end address is formed 18 bits wider than the address so that a huge
  // base plus a huge word count cannot wrap around and pass the check.
  assign w_end_addr    = {18'd0, r_addr} + {64'd0, r_remaining, 2'b00};
  assign w_bad_request = (r_addr[1:0] != 2'b00) || (w_end_addr > 82'(MEM_BYTES));

  // Select the byte of the held word addressed by the byte counter.
  always_comb begin
    w_cur_byte = r_word[7:0];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_word[7:0];
      2'd1:    w_cur_byte = r_word[15:8];
      2'd2:    w_cur_byte = r_word[23:16];
      default: w_cur_byte = r_word[31:24];
    endcase
  end

  // State register; reset overrides every transition.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = CHECK;
        end
      end
      CHECK: begin
        if (w_bad_request) begin
          w_next_state = IDLE;
        end else if (r_remaining == 16'd0) begin
          w_next_state = DONE;
        end else begin
          w_next_state = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (i_word_valid) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (r_byte_idx == 2'd3) begin
          w_next_state = (r_remaining == 16'd1) ? DONE : WAIT_WORD;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: latch the request, capture words, and step address/byte counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_addr       <= 64'd0;
      r_remaining  <= 16'd0;
      r_byte_idx   <= 2'd0;
      r_word       <= 32'd0;
      r_last_addr  <= 64'd0;
      r_last_wdata <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_num_words;
          end
        end
        WAIT_WORD: begin
          if (i_word_valid) begin
            r_word     <= i_word_data;
            r_byte_idx <= 2'd0;
          end
        end
        WRITE: begin
          r_last_addr  <= r_addr;
          r_last_wdata <= w_cur_byte;
          r_addr       <= r_addr + 64'd1;
          r_byte_idx   <= r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            r_remaining <= r_remaining - 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs; the write port shows the live byte in WRITE and otherwise
  // holds the most recently written address/data.
  always_comb begin
    o_word_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = r_last_addr;
    o_mem_wdata  = r_last_wdata;
    o_busy       = (r_state != IDLE);
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      CHECK: begin
        o_error = w_bad_request;
      end
      WAIT_WORD: begin
        o_word_ready = 1'b1;
      end
      WRITE: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = r_addr;
        o_mem_wdata = w_cur_byte;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed self-checking bench for instruction_memory_loader.
// Inputs change 1 time unit after the rising edge; a negedge monitor logs
// every byte write and counts done/error pulses.

module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [63:0] baseAddr;
  logic [15:0] numWords;
  logic        wordValid;
  logic [31:0] wordData;
  logic        wordReady;
  logic        memWe;
  logic [63:0] memAddr;
  logic [7:0]  memWdata;
  logic        busy;
  logic        done;
  logic        error;

  int nChecks = 0;
  int nPass   = 0;

  logic [63:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];
  int          doneCnt    = 0;
  int          errCnt     = 0;
  int          overlapCnt = 0;

  // Little-endian bytes of 0x02853483, 0x009A84B3, 0x00148493, 0x02953423.
  logic [7:0] expBytes [0:15] = '{
    8'h83, 8'h34, 8'h85, 8'h02,
    8'hB3, 8'h84, 8'h9A, 8'h00,
    8'h93, 8'h84, 8'h14, 8'h00,
    8'h23, 8'h34, 8'h95, 8'h02
  };

  instruction_memory_loader #(.MEM_BYTES(16)) dut (
    .i_clk        (clk),
    .i_reset      (rstN),
    .i_start      (start),
    .i_base_addr  (baseAddr),
    .i_num_words  (numWords),
    .i_word_valid (wordValid),
    .i_word_data  (wordData),
    .o_word_ready (wordReady),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  // Log writes and pulses mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (memWe) begin
      wrAddrQ.push_back(memAddr);
      wrDataQ.push_back(memWdata);
    end
    if (done) doneCnt++;
    if (error) errCnt++;
    if (memWe && wordReady) overlapCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [63:0] base, input logic [15:0] num);
    start    = 1'b1;
    baseAddr = base;
    numWords = num;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for ready, then hand over one word; returns in the first WRITE cycle.
  task automatic sendWord(input logic [31:0] data);
    int k = 0;
    while (!wordReady && k < 50) begin
      tick();
      k++;
    end
    nChecks++;
    if (wordReady !== 1'b1) $display("[TB] FAIL ready_timeout: word_ready=%b required 1", wordReady);
    else nPass++;
    wordValid = 1'b1;
    wordData  = data;
    tick();
    wordValid = 1'b0;
    wordData  = 32'hDEADBEEF;
  endtask

  task automatic waitDone(input int base);
    int k = 0;
    while (doneCnt == base && k < 80) begin
      tick();
      k++;
    end
    nChecks++;
    if (doneCnt - base !== 1) $display("[TB] FAIL done_count: got %0d required 1", doneCnt - base);
    else nPass++;
  endtask

  task automatic test_reset();
    rstN      = 1'b0;
    start     = 1'b1;
    wordValid = 1'b1;
    baseAddr  = 64'd4;
    numWords  = 16'd1;
    wordData  = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      nChecks++;
      if ({wordReady, memWe, memAddr, memWdata, busy, done, error} !== 77'd0)
        $display("[TB] FAIL reset_outputs: ready=%b we=%b addr=%0h wdata=%0h busy=%b done=%b err=%b required all 0",
                 wordReady, memWe, memAddr, memWdata, busy, done, error);
      else nPass++;
    end
    rstN      = 1'b1;
    start     = 1'b0;
    wordValid = 1'b0;
    tick();
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_idle: busy=%b required 0", busy);
    else nPass++;
  endtask

  task automatic test_single_word();
    int qb = wrAddrQ.size();
    int db = doneCnt;
    doStart(64'd0, 16'd1);
    nChecks++;
    if ({busy, wordReady, error} !== 3'b100) $display("[TB] FAIL single_check_state: busy/ready/err=%b required 100", {busy, wordReady, error});
    else nPass++;
    tick();
    nChecks++;
    if (wordReady !== 1'b1) $display("[TB] FAIL single_first_ready: word_ready=%b required 1", wordReady);
    else nPass++;
    wordValid = 1'b1;
    wordData  = 32'h02853483;
    tick();
    wordValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if ({memWe, wordReady} !== 2'b10 || memAddr !== 64'(i) || memWdata !== expBytes[i])
        $display("[TB] FAIL single_write%0d: we=%b ready=%b addr=%0h data=%h required we=1 ready=0 addr=%0h data=%h",
                 i, memWe, wordReady, memAddr, memWdata, i, expBytes[i]);
      else nPass++;
      tick();
    end
    nChecks++;
    if ({done, busy, memWe} !== 3'b110) $display("[TB] FAIL single_done: done/busy/we=%b required 110", {done, busy, memWe});
    else nPass++;
    tick();
    nChecks++;
    if ({done, busy} !== 2'b00) $display("[TB] FAIL single_after_done: done/busy=%b required 00", {done, busy});
    else nPass++;
    nChecks++;
    if (wrAddrQ.size() - qb !== 4 || doneCnt - db !== 1)
      $display("[TB] FAIL single_counts: writes=%0d dones=%0d required 4 and 1", wrAddrQ.size() - qb, doneCnt - db);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int qb = wrAddrQ.size();
    int db = doneCnt;
    int ob = overlapCnt;
    logic [31:0] words [0:3] = '{32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423};
    doStart(64'd0, 16'd4);
    for (int w = 0; w < 4; w++) begin
      if (w == 2) begin
        while (!wordReady) tick();
        repeat (3) tick();
      end
      sendWord(words[w]);
    end
    waitDone(db);
    nChecks++;
    if (wrAddrQ.size() - qb !== 16) $display("[TB] FAIL four_write_count: got %0d required 16", wrAddrQ.size() - qb);
    else nPass++;
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if (wrAddrQ[qb + i] !== 64'(i) || wrDataQ[qb + i] !== expBytes[i])
        $display("[TB] FAIL four_byte%0d: addr=%0h data=%h required addr=%0h data=%h",
                 i, wrAddrQ[qb + i], wrDataQ[qb + i], i, expBytes[i]);
      else nPass++;
    end
    nChecks++;
    if (overlapCnt - ob !== 0) $display("[TB] FAIL four_ready_in_write: got %0d cycles required 0", overlapCnt - ob);
    else nPass++;
  endtask

  task automatic test_rejects();
    logic [63:0] badBase [0:1] = '{64'd2, 64'd12};
    logic [15:0] badNum  [0:1] = '{16'd1, 16'd2};
    int qb;
    int eb;
    int db;
    for (int r = 0; r < 2; r++) begin
      qb = wrAddrQ.size();
      eb = errCnt;
      doStart(badBase[r], badNum[r]);
      nChecks++;
      if ({error, busy} !== 2'b11) $display("[TB] FAIL reject%0d_pulse: err/busy=%b required 11", r, {error, busy});
      else nPass++;
      tick();
      nChecks++;
      if ({error, busy, wordReady} !== 3'b000) $display("[TB] FAIL reject%0d_after: err/busy/ready=%b required 000", r, {error, busy, wordReady});
      else nPass++;
      repeat (3) tick();
      nChecks++;
      if (wrAddrQ.size() - qb !== 0 || errCnt - eb !== 1)
        $display("[TB] FAIL reject%0d_counts: writes=%0d errors=%0d required 0 and 1", r, wrAddrQ.size() - qb, errCnt - eb);
      else nPass++;
    end
    qb = wrAddrQ.size();
    eb = errCnt;
    db = doneCnt;
    doStart(64'd12, 16'd1);
    nChecks++;
    if (error !== 1'b0) $display("[TB] FAIL edge_no_error: err=%b required 0", error);
    else nPass++;
    sendWord(32'h02853483);
    waitDone(db);
    nChecks++;
    if (wrAddrQ.size() - qb !== 4 || errCnt - eb !== 0)
      $display("[TB] FAIL edge_counts: writes=%0d errors=%0d required 4 and 0", wrAddrQ.size() - qb, errCnt - eb);
    else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (wrAddrQ[qb + i] !== 64'(12 + i) || wrDataQ[qb + i] !== expBytes[i])
        $display("[TB] FAIL edge_byte%0d: addr=%0h data=%h required addr=%0h data=%h",
                 i, wrAddrQ[qb + i], wrDataQ[qb + i], 12 + i, expBytes[i]);
      else nPass++;
    end
  endtask

  task automatic test_empty_and_ignored_start();
    int qb = wrAddrQ.size();
    int db;
    doStart(64'd0, 16'd0);
    tick();
    nChecks++;
    if ({done, busy} !== 2'b11) $display("[TB] FAIL empty_done: done/busy=%b required 11", {done, busy});
    else nPass++;
    tick();
    nChecks++;
    if ({done, busy} !== 2'b00 || wrAddrQ.size() - qb !== 0)
      $display("[TB] FAIL empty_after: done/busy=%b writes=%0d required 00 and 0", {done, busy}, wrAddrQ.size() - qb);
    else nPass++;

    qb = wrAddrQ.size();
    db = doneCnt;
    doStart(64'd4, 16'd1);
    sendWord(32'h009A84B3);
    start    = 1'b1;
    baseAddr = 64'd8;
    numWords = 16'd3;
    tick();
    start = 1'b0;
    waitDone(db);
    repeat (2) tick();
    nChecks++;
    if (busy !== 1'b0 || wrAddrQ.size() - qb !== 4)
      $display("[TB] FAIL ignore_start_counts: busy=%b writes=%0d required 0 and 4", busy, wrAddrQ.size() - qb);
    else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (wrAddrQ[qb + i] !== 64'(4 + i) || wrDataQ[qb + i] !== expBytes[4 + i])
        $display("[TB] FAIL ignore_start_byte%0d: addr=%0h data=%h required addr=%0h data=%h",
                 i, wrAddrQ[qb + i], wrDataQ[qb + i], 4 + i, expBytes[4 + i]);
      else nPass++;
    end
  endtask

  task automatic test_reset_mid_write();
    int qb = wrAddrQ.size();
    int db;
    doStart(64'd0, 16'd1);
    sendWord(32'h02853483);
    tick();
    rstN = 1'b0;
    tick();
    nChecks++;
    if ({memWe, busy, wordReady, done} !== 4'b0000 || memAddr !== 64'd0 || memWdata !== 8'd0)
      $display("[TB] FAIL midreset_state: we/busy/ready/done=%b addr=%0h data=%h required 0000 0 0",
               {memWe, busy, wordReady, done}, memAddr, memWdata);
    else nPass++;
    tick();
    rstN = 1'b1;
    tick();
    nChecks++;
    if (wrAddrQ.size() - qb !== 2 || busy !== 1'b0)
      $display("[TB] FAIL midreset_writes: writes=%0d busy=%b required 2 and 0", wrAddrQ.size() - qb, busy);
    else nPass++;

    qb = wrAddrQ.size();
    db = doneCnt;
    doStart(64'd8, 16'd1);
    sendWord(32'h00148493);
    waitDone(db);
    nChecks++;
    if (wrAddrQ.size() - qb !== 4) $display("[TB] FAIL restart_count: got %0d required 4", wrAddrQ.size() - qb);
    else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (wrAddrQ[qb + i] !== 64'(8 + i) || wrDataQ[qb + i] !== expBytes[8 + i])
        $display("[TB] FAIL restart_byte%0d: addr=%0h data=%h required addr=%0h data=%h",
                 i, wrAddrQ[qb + i], wrDataQ[qb + i], 8 + i, expBytes[8 + i]);
      else nPass++;
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN      = 1'b0;
    start     = 1'b0;
    baseAddr  = 64'd0;
    numWords  = 16'd0;
    wordValid = 1'b0;
    wordData  = 32'd0;
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_rejects();
    test_empty_and_ignored_start();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
